// File: rtl/vid_fb_pkg.sv
// Shared constants and helpers for the banked SPRAM video framebuffer.
// Bank index width and the byte-mask to SPRAM nibble-enable mapping live here.
package vid_fb_pkg;

   localparam int SPRAM_AW    = 14;
   localparam int DW          = 32;
   localparam int SPRAM_WORDS = 1 << SPRAM_AW;

   typedef enum logic [1:0] {
      GRANT_IDLE = 2'd0,
      GRANT_VID  = 2'd1,
      GRANT_AUX  = 2'd2
   } grant_e;

   function automatic int bank_idx_w(input int n_banks);
      return (n_banks <= 1) ? 0 : $clog2(n_banks);
   endfunction

   // Each byte enable drives both nibble enables of that byte; SPRAM enables are active-low.
   function automatic logic [7:0] byte_to_nib_we_n(input logic [3:0] bmask);
      logic [7:0] nib;
      nib = '1;
      for (int i = 0; i < 4; i++) begin
         nib[2*i]   = ~bmask[i];
         nib[2*i+1] = ~bmask[i];
      end
      return nib;
   endfunction

endpackage

// File: rtl/vid_framebuf_burst_if.sv
// Video burst/stream and aux bus signals of the framebuffer, with system-side
// (master) and framebuffer-side (slave) views.
interface vid_framebuf_burst_if #(
   parameter int AW = 15,
   parameter int LW = 10
);
   import vid_fb_pkg::*;

   logic          v_start;
   logic [AW-1:0] v_start_addr;
   logic [LW-1:0] v_start_len;
   logic          v_busy;
   logic [DW-1:0] v_data;
   logic          v_valid;
   logic          v_ready;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic [3:0]    a_wmsk;
   logic          a_we;
   logic          a_valid;
   logic          a_ready;
   logic [DW-1:0] a_rdata;
   logic          a_rvalid;

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
   // The requester holds its payload stable while valid is high and ready is low;
   // ready may depend combinationally on valid. a_rvalid is a one-cycle pulse, no back-pressure.
   modport master (
      output v_start, v_start_addr, v_start_len, v_ready,
      output a_addr, a_wdata, a_wmsk, a_we, a_valid,
      input  v_busy, v_data, v_valid, a_ready, a_rdata, a_rvalid
   );

   modport slave (
      input  v_start, v_start_addr, v_start_len, v_ready,
      input  a_addr, a_wdata, a_wmsk, a_we, a_valid,
      output v_busy, v_data, v_valid, a_ready, a_rdata, a_rvalid
   );

endinterface

// File: rtl/vid_fb_fifo.sv
// First-word-fall-through prefetch FIFO with synchronous flush and fill level.
// Overflow is prevented upstream by credits; the full guard here is only a backstop.
module vid_fb_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   output logic [W-1:0]           rdata,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] fill
);

   localparam int PW = $clog2(DEPTH);
   localparam int FW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign valid   = (fill != '0);
   assign do_push = push && (fill != FW'(DEPTH));
   assign do_pop  = pop && valid;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/vid_framebuf_burst.sv
// Banked SPRAM framebuffer: video burst prefetch into a FWFT FIFO plus a
// credit-arbitrated aux port, one memory access per cycle.
module vid_framebuf_burst
   import vid_fb_pkg::*;
#(
   parameter int N_BANKS    = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_LWM   = 4,
   parameter int LW         = 10
) (
   input  logic                clk,
   input  logic                rst,
   vid_framebuf_burst_if.slave bus
);

   localparam int BW_RAW = bank_idx_w(N_BANKS);
   localparam int BIW    = (BW_RAW == 0) ? 1 : BW_RAW;
   localparam int AW     = SPRAM_AW + BW_RAW;
   localparam int FW     = $clog2(FIFO_DEPTH) + 1;
   localparam int LVW    = FW + 1;

   logic [AW-1:0]       v_addr;
   logic [LW-1:0]       remaining;
   logic                vid_rd_q;
   logic                aux_rd_q;
   logic [BIW-1:0]      bank_q;

   logic                flush;
   logic [AW-1:0]       eff_addr;
   logic [LW-1:0]       eff_rem;
   logic [LVW-1:0]      eff_level;
   logic                vid_need;
   logic                vid_urgent;
   grant_e              grant;

   logic [AW-1:0]       mem_addr;
   logic [SPRAM_AW-1:0] mem_row;
   logic                mem_we;
   logic [7:0]          nib_we_n;
   logic [BIW-1:0]      bank_sel;
   logic [N_BANKS-1:0]  bank_cs;

   logic [DW-1:0]       spram [N_BANKS][SPRAM_WORDS];
   logic [DW-1:0]       bank_rdata [N_BANKS];
   logic [DW-1:0]       rd_word;
   logic [FW-1:0]       fill;

   // A new burst is seen by arbitration in its own cycle: the flushed FIFO and the
   // dropped in-flight read no longer count against credit.
   always_comb begin
      flush      = bus.v_start && !rst;
      eff_addr   = flush ? bus.v_start_addr : v_addr;
      eff_rem    = flush ? bus.v_start_len : remaining;
      eff_level  = flush ? '0 : (LVW'(fill) + LVW'(vid_rd_q));
      vid_need   = (eff_rem != '0) && (eff_level < LVW'(FIFO_DEPTH));
      vid_urgent = vid_need && (eff_level < LVW'(FIFO_LWM));
      grant      = GRANT_IDLE;
      if (rst)               grant = GRANT_IDLE;
      else if (vid_urgent)   grant = GRANT_VID;
      else if (bus.a_valid)  grant = GRANT_AUX;
      else if (vid_need)     grant = GRANT_VID;
   end

   always_comb begin
      mem_addr = (grant == GRANT_AUX) ? bus.a_addr : eff_addr;
      mem_row  = mem_addr[SPRAM_AW-1:0];
      mem_we   = (grant == GRANT_AUX) && bus.a_we;
      nib_we_n = byte_to_nib_we_n(bus.a_wmsk);
      bank_sel = BIW'(mem_addr >> SPRAM_AW);
      bank_cs  = '0;
      for (int b = 0; b < N_BANKS; b++) begin
         bank_cs[b] = (grant != GRANT_IDLE) && (bank_sel == BIW'(b));
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < N_BANKS; b++) begin
         if (bank_cs[b]) begin
            if (mem_we) begin
               for (int n = 0; n < 8; n++) begin
                  if (!nib_we_n[n]) spram[b][mem_row][n*4 +: 4] <= bus.a_wdata[n*4 +: 4];
               end
            end else begin
               bank_rdata[b] <= spram[b][mem_row];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_addr    <= '0;
         remaining <= '0;
         vid_rd_q  <= 1'b0;
         aux_rd_q  <= 1'b0;
         bank_q    <= '0;
      end else begin
         v_addr    <= eff_addr + AW'(grant == GRANT_VID);
         remaining <= eff_rem - LW'(grant == GRANT_VID);
         vid_rd_q  <= (grant == GRANT_VID);
         aux_rd_q  <= (grant == GRANT_AUX) && !bus.a_we;
         bank_q    <= bank_sel;
      end
   end

   assign rd_word      = bank_rdata[bank_q];
   assign bus.a_ready  = (grant == GRANT_AUX);
   assign bus.a_rvalid = aux_rd_q;
   assign bus.a_rdata  = rd_word;
   assign bus.v_busy   = (remaining != '0) || vid_rd_q;

   // A flush in the cycle a stale read returns discards that word inside the FIFO.
   vid_fb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (vid_rd_q),
      .wdata (rd_word),
      .pop   (bus.v_ready),
      .rdata (bus.v_data),
      .valid (bus.v_valid),
      .fill  (fill)
   );

endmodule

// File: tb/tb_vid_framebuf_burst.sv
// Directed bench for vid_framebuf_burst: bursts, aux arbitration, masks, wrap,
// abort, cancel and reset, with an expected-word queue for the video stream.
module tb_vid_framebuf_burst;
  import vid_fb_pkg::*;

  localparam int AW = 15;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  int first_c, last_c;
  logic busy_first, busy_last;
  int waits;
  logic [31:0] rd;
  logic rv;
  logic got;

  vid_framebuf_burst_if #(.AW(AW), .LW(LW)) ifc ();

  vid_framebuf_burst #(
    .N_BANKS(2), .FIFO_DEPTH(16), .FIFO_LWM(4), .LW(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic start_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    ifc.v_start = 1'b1;
    ifc.v_start_addr = addr;
    ifc.v_start_len = len;
    @(negedge clk);
    ifc.v_start = 1'b0;
  endtask

  task automatic aux_xfer(input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] msk, input logic we,
                          output int w, output logic [31:0] rdata, output logic rvalid);
    logic acc;
    acc = 1'b0;
    w = 0;
    ifc.a_addr = addr;
    ifc.a_wdata = wdata;
    ifc.a_wmsk = msk;
    ifc.a_we = we;
    ifc.a_valid = 1'b1;
    while (!acc && w < 64) begin
      #1;
      if (ifc.a_ready) acc = 1'b1;
      else w++;
      @(negedge clk);
    end
    ifc.a_valid = 1'b0;
    #1;
    rdata = ifc.a_rdata;
    rvalid = ifc.a_rvalid;
  endtask

  task automatic preload(input logic [AW-1:0] addr);
    int w;
    logic [31:0] r;
    logic v;
    aux_xfer(addr, pat(addr), 4'hF, 1'b1, w, r, v);
    check("preload_wait", w, 0);
    @(negedge clk);
  endtask

  // scoreboard: pops exp_q for every word the pixel side consumes
  task automatic drain(input int nwords);
    int seen;
    seen = 0;
    ifc.v_ready = 1'b1;
    for (int c = 0; c < 64 && seen < nwords; c++) begin
      #1;
      if (ifc.v_valid) begin
        if (seen == 0) begin
          first_c = c;
          busy_first = ifc.v_busy;
        end
        last_c = c;
        busy_last = ifc.v_busy;
        if (exp_q.size() > 0) check("v_data", ifc.v_data, exp_q.pop_front());
        else check("v_data_extra", ifc.v_data, 32'hDEAD_BEEF);
        seen++;
      end
      @(negedge clk);
    end
    check("drain_count", seen, nwords);
  endtask

  initial begin
    rst = 1'b1;
    ifc.v_start = 1'b0;
    ifc.v_start_addr = '0;
    ifc.v_start_len = '0;
    ifc.v_ready = 1'b0;
    ifc.a_addr = AW'(32'h20);
    ifc.a_wdata = '0;
    ifc.a_wmsk = '0;
    ifc.a_we = 1'b0;
    ifc.a_valid = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check1("rst_a_ready", ifc.a_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ifc.a_valid = 1'b0;
    #1;
    check1("rst_v_valid", ifc.v_valid, 1'b0);
    check1("rst_v_busy", ifc.v_busy, 1'b0);
    check1("rst_a_rvalid", ifc.a_rvalid, 1'b0);
    @(negedge clk);

    // preload memory through the aux port
    aux_xfer(AW'(32'h100), pat(AW'(32'h100)), 4'hF, 1'b1, waits, rd, rv);
    check("wr_wait", waits, 0);
    check1("wr_no_rvalid", rv, 1'b0);
    @(negedge clk);
    for (int i = 1; i < 8; i++) preload(AW'(32'h100 + i));
    for (int i = 0; i < 16; i++) preload(AW'(32'h300 + i));
    preload(AW'(32'h200));
    preload(AW'(32'h201));
    preload(AW'(32'h20));
    preload(AW'(32'h7FFE));
    preload(AW'(32'h7FFF));
    preload(AW'(32'h0));
    preload(AW'(32'h1));
    preload(AW'(32'h4000));
    preload(AW'(32'h4001));

    // basic burst
    for (int i = 0; i < 8; i++) exp_q.push_back(pat(AW'(32'h100 + i)));
    ifc.v_ready = 1'b1;
    start_burst(AW'(32'h100), LW'(8));
    drain(8);
    ifc.v_ready = 1'b0;
    check("basic_first_cycle", first_c, 1);
    check("basic_last_cycle", last_c, 8);
    check1("basic_busy_mid", busy_first, 1'b1);
    check1("basic_busy_end", busy_last, 1'b0);
    @(negedge clk);

    // aux waits while fill+inflight < LWM during an active burst
    ifc.v_start = 1'b1;
    ifc.v_start_addr = AW'(32'h300);
    ifc.v_start_len = LW'(16);
    ifc.a_addr = AW'(32'h20);
    ifc.a_we = 1'b0;
    ifc.a_valid = 1'b1;
    waits = 0;
    got = 1'b0;
    while (!got && waits < 64) begin
      #1;
      if (ifc.a_ready) got = 1'b1;
      else waits++;
      @(negedge clk);
      ifc.v_start = 1'b0;
    end
    ifc.a_valid = 1'b0;
    #1;
    check("aux_lwm_wait", waits, 4);
    check1("aux_lwm_rvalid", ifc.a_rvalid, 1'b1);
    check("aux_lwm_rdata", ifc.a_rdata, pat(AW'(32'h20)));
    check1("aux_lwm_busy", ifc.v_busy, 1'b1);

    // FIFO fills to depth, then aux gets the memory at once
    for (int c = 0; c < 64 && ifc.v_busy; c++) @(negedge clk);
    #1;
    check1("full_busy", ifc.v_busy, 1'b0);
    check1("full_valid", ifc.v_valid, 1'b1);
    @(negedge clk);
    aux_xfer(AW'(32'h7FFF), 32'h0, 4'h0, 1'b0, waits, rd, rv);
    check("full_aux_wait", waits, 0);
    check1("full_aux_rvalid", rv, 1'b1);
    check("full_aux_rdata", rd, pat(AW'(32'h7FFF)));
    @(negedge clk);
    for (int i = 0; i < 16; i++) exp_q.push_back(pat(AW'(32'h300 + i)));
    drain(16);
    ifc.v_ready = 1'b0;
    #1;
    check1("drained_empty", ifc.v_valid, 1'b0);
    @(negedge clk);

    // masked writes
    aux_xfer(AW'(32'h40), 32'hAABB_CCDD, 4'b1111, 1'b1, waits, rd, rv);
    @(negedge clk);
    aux_xfer(AW'(32'h40), 32'h1122_3344, 4'b0101, 1'b1, waits, rd, rv);
    @(negedge clk);
    aux_xfer(AW'(32'h40), 32'h0, 4'h0, 1'b0, waits, rd, rv);
    check1("mask_rvalid", rv, 1'b1);
    check("mask_0101", rd, 32'hAA22_CC44);
    @(negedge clk);
    aux_xfer(AW'(32'h40), 32'h5566_7788, 4'b1000, 1'b1, waits, rd, rv);
    @(negedge clk);
    aux_xfer(AW'(32'h40), 32'h0, 4'h0, 1'b0, waits, rd, rv);
    check("mask_1000", rd, 32'h5522_CC44);
    @(negedge clk);

    // bank crossing and address wrap
    exp_q.push_back(pat(AW'(32'h7FFE)));
    exp_q.push_back(pat(AW'(32'h7FFF)));
    exp_q.push_back(pat(AW'(32'h0)));
    exp_q.push_back(pat(AW'(32'h1)));
    ifc.v_ready = 1'b1;
    start_burst(AW'(32'h7FFE), LW'(4));
    drain(4);
    ifc.v_ready = 1'b0;
    @(negedge clk);

    // abort mid-burst after three pops
    for (int i = 0; i < 3; i++) exp_q.push_back(pat(AW'(32'h300 + i)));
    ifc.v_ready = 1'b1;
    start_burst(AW'(32'h300), LW'(16));
    drain(3);
    ifc.v_ready = 1'b0;
    exp_q.push_back(pat(AW'(32'h200)));
    exp_q.push_back(pat(AW'(32'h201)));
    start_burst(AW'(32'h200), LW'(2));
    drain(2);
    #1;
    check1("abort_empty", ifc.v_valid, 1'b0);
    check1("abort_busy", ifc.v_busy, 1'b0);
    @(negedge clk);
    #1;
    check1("abort_no_stale", ifc.v_valid, 1'b0);
    ifc.v_ready = 1'b0;
    @(negedge clk);

    // zero-length start cancels a running burst
    start_burst(AW'(32'h100), LW'(8));
    @(negedge clk);
    @(negedge clk);
    start_burst(AW'(32'h100), LW'(0));
    #1;
    check1("cancel_busy", ifc.v_busy, 1'b0);
    check1("cancel_valid", ifc.v_valid, 1'b0);
    @(negedge clk);
    #1;
    check1("cancel_valid_later", ifc.v_valid, 1'b0);
    @(negedge clk);

    // reset during a burst with an aux read pending
    start_burst(AW'(32'h300), LW'(16));
    @(negedge clk);
    rst = 1'b1;
    ifc.a_addr = AW'(32'h20);
    ifc.a_we = 1'b0;
    ifc.a_valid = 1'b1;
    #1;
    check1("midrst_a_ready", ifc.a_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ifc.a_valid = 1'b0;
    #1;
    check1("midrst_v_valid", ifc.v_valid, 1'b0);
    check1("midrst_v_busy", ifc.v_busy, 1'b0);
    check1("midrst_a_rvalid", ifc.a_rvalid, 1'b0);
    @(negedge clk);
    #1;
    check1("midrst_a_rvalid_next", ifc.a_rvalid, 1'b0);
    check1("midrst_v_valid_next", ifc.v_valid, 1'b0);
    @(negedge clk);

    // burst after reset
    exp_q.push_back(pat(AW'(32'h200)));
    exp_q.push_back(pat(AW'(32'h201)));
    start_burst(AW'(32'h200), LW'(2));
    drain(2);
    ifc.v_ready = 1'b0;
    check("exp_q_left", exp_q.size(), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
